stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control block for the 50 MHz MM:SS.cc stopwatch. It takes two raw push-buttons, start/stop and lap/reset, and synchronises and debounces them. A four-state machine then drives the enable and clear of the cascaded counter chain, and a lap register plus mux lets the display freeze while counting continues. It sits between the board buttons, the counter chain (centiseconds 0–99, seconds 0–59, minutes 0–59) and the per-digit 7-segment decoders.

## Interface
Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- DEB_W, 19: debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- btn_ss  in  1  start/stop button, active-high, asynchronous to clk.
- btn_lr  in  1  lap/reset button, active-high, asynchronous to clk.
- live_cs  in  7  current centisecond count, 0–99.
- live_s  in  6  current second count, 0–59.
- live_m  in  6  current minute count, 0–59.
- cnt_en  out  1  enable to the first (0.01 s prescaler) stage of the chain.
- cnt_clr  out  1  active-high clear of the whole chain, registered.
- disp_cs  out  7  centiseconds to the decoders.
- disp_s  out  6  seconds to the decoders.
- disp_m  out  6  minutes to the decoders.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

## Operation
- **Sync:** each button passes through a 2-FF synchroniser (reset 0).
- **Debounce:** each button has a counter and a debounced level db, both reset 0.
  - When the synced level equals db, the counter clears.
  - When it differs, the counter increments.
  - On the DEB_CYCLES-th consecutive differing cycle, db toggles and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles never reach db.
- **Press event:** a one-cycle pulse on the cycle after db rises (db & ~db_q). Release of a button produces no event.
- **Priority:** if ss and lr events occur in the same cycle, ss wins and lr is discarded.
- **FSM transitions** (events not listed leave the state unchanged):
  - IDLE: ss → RUN. lr → stay in IDLE and issue a cnt_clr pulse.
  - RUN: ss → PAUSE. lr → LAP, and load the lap registers from the live_* inputs on the same edge.
  - LAP: lr → RUN. ss → PAUSE.
  - PAUSE: ss → RUN. lr → IDLE and issue a cnt_clr pulse.
- **cnt_en:** 1 in RUN and LAP, 0 in IDLE and PAUSE. It is a combinational decode of the registered state.
- **Display mux:** disp_* = lap registers in LAP, live_* in every other state.
- **Lap registers:** 7+6+6 bits, reset 0, written only on the RUN→LAP edge. The captured value is live_* as sampled at that edge, i.e. the pre-increment value.
- **Rollover:** counter rollover at 59:59.99 is handled by the chain; the controller takes no action.

## Timing
- **Reset values:** state=IDLE, cnt_en=0, lap registers 0, sync/db/counters 0, disp_*=live_*.
- **cnt_clr during reset:** cnt_clr=1 during every cycle following an edge with rst=1, so the chain clears together with the controller.
- **Button latency:** a clean press rising at cycle 0 (already synchronised) sets db at cycle DEB_CYCLES, and the event pulse is high for cycle DEB_CYCLES+1. The state changes at the end of that cycle. cnt_en and disp_* follow in the same cycle as the new state.
- **cnt_clr pulse:** registered, high for exactly one cycle, coincident with the cycle after the transition edge (IDLE→IDLE or PAUSE→IDLE).
- **Held buttons:** a held button produces exactly one event. A new event requires the button to be released (db falls) and pressed again.
- **Reset mid-operation:** in any state, one rst cycle forces IDLE with lap registers 0. Any debounce in progress is abandoned; a button still held after rst is re-debounced and yields a fresh event.

## Test plan
All scenarios use DEB_CYCLES=4 and DEB_W=3.
- **Reset:** rst=1 for 2 cycles, then 0 → state=00, cnt_en=0, cnt_clr=1 until the first edge with rst=0, then 0, disp_*=live_*.
- **Debounce:** btn_ss high 3 cycles → no state change. btn_ss high 10 cycles → exactly one event, state=01, cnt_en=1. The transition occurs 2+4+1 cycles after the raw rise, counting the synchroniser.
- **Lap freeze:** in RUN with live 05:34.12, press lr → state=11, disp=05:34.12 held while live_* keeps changing, cnt_en=1. Press lr again → state=01, disp=live_*.
- **Pause and clear:** from RUN, press ss → state=10, cnt_en=0. Press lr → state=00, cnt_clr high for exactly 1 cycle. A further lr in IDLE → state stays 00, cnt_clr pulses once more.
- **Simultaneous presses:** in RUN, ss and lr debounce-complete on the same cycle → state=10, lap registers unchanged (still 0), no cnt_clr.
- **Reset in LAP:** in LAP, assert rst for 1 cycle → state=00, cnt_en=0, lap registers 0, disp_*=live_*.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, run/pause/lap FSM, counter-chain
// enable/clear and lap-freeze display mux.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [6:0] live_cs,
    input  logic [5:0] live_s,
    input  logic [5:0] live_m,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [6:0] disp_cs,
    output logic [5:0] disp_s,
    output logic [5:0] disp_m,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           st;
    logic [1:0]       btn_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [1:0]       db_q;
    logic [1:0]       ev;
    logic [DEB_W-1:0] deb_cnt [2];
    logic [6:0]       lap_cs;
    logic [5:0]       lap_s;
    logic [5:0]       lap_m;
    logic             ss_ev;
    logic             lr_ev;

    // Bit 0 carries start/stop, bit 1 carries lap/reset.
    assign btn_raw = {btn_lr, btn_ss};
    assign ss_ev   = ev[0];
    assign lr_ev   = ev[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            ev    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            ev    <= db & ~db_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    db[i]      <= ~db[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Start/stop takes priority: a lap/reset event in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            cnt_clr <= 1'b1;
            lap_cs  <= '0;
            lap_s   <= '0;
            lap_m   <= '0;
        end else begin
            cnt_clr <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (ss_ev)      st <= RUN;
                    else if (lr_ev) cnt_clr <= 1'b1;
                end
                RUN: begin
                    if (ss_ev) begin
                        st <= PAUSE;
                    end else if (lr_ev) begin
                        st     <= LAP;
                        lap_cs <= live_cs;
                        lap_s  <= live_s;
                        lap_m  <= live_m;
                    end
                end
                LAP: begin
                    if (ss_ev)      st <= PAUSE;
                    else if (lr_ev) st <= RUN;
                end
                PAUSE: begin
                    if (ss_ev) begin
                        st <= RUN;
                    end else if (lr_ev) begin
                        st      <= IDLE;
                        cnt_clr <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign cnt_en = (st == RUN) || (st == LAP);
    assign state  = st;

    always_comb begin
        disp_cs = live_cs;
        disp_s  = live_s;
        disp_m  = live_m;
        if (st == LAP) begin
            disp_cs = lap_cs;
            disp_s  = lap_s;
            disp_m  = lap_m;
        end
    end

endmodule
